sar_search_ctrl: RTL

//  Successive-approximation (binary-search) controller: the consuming end of the magnitude comparator interface.

---
 rtl/sar_search_ctrl_pkg.sv | 15 +
 rtl/sar_search_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl_pkg.sv
// Shared definitions for the successive-approximation search controller:
// the FSM state type and the default search geometry.
package sar_search_ctrl_pkg;

    localparam int SAR_WIDTH  = 4;
    localparam int MAX_VAL    = 2**SAR_WIDTH - 1;
    localparam int MAX_PROBES = SAR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } sar_state_e;

endpackage

// File: rtl/sar_search_ctrl.sv
// Binary-search controller sitting on the b side of a magnitude comparator.
// Each probe presents a guess, reads back lt/gt/eq on the next edge and
// halves the remaining interval [lo, hi] until the target is hit, the
// interval empties, or the comparator reports an impossible flag pattern.
module sar_search_ctrl
    import sar_search_ctrl_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             cmp_lt_i,
    input  logic             cmp_gt_i,
    input  logic             cmp_eq_i,
    output logic [WIDTH-1:0] guess_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             found_o,
    output logic             err_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int RW      = WIDTH + 1;
    localparam int EW      = WIDTH + 2;
    localparam int TOP_INT = 2**WIDTH - 1;
    localparam logic [EW-1:0] ONE_EXT = EW'(1);

    sar_state_e       state_q;
    logic [WIDTH:0]   lo_q, hi_q;
    logic [WIDTH:0]   lo_d, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q;
    logic             busy_q, done_q, found_q, err_q;

    logic [EW-1:0]    loExt, hiExt;
    logic             flagsOneHot;
    logic             rangeEmpty;

    // Narrow the interval from the comparator verdict on the current guess.
    // The math runs two bits wider than the operand and is compared signed,
    // so guess-1 at zero shows up as -1 and empties the range instead of wrapping.
    always_comb begin
        loExt = {1'b0, lo_q};
        hiExt = {1'b0, hi_q};
        if (cmp_lt_i) begin
            hiExt = {2'b00, guess_q} - ONE_EXT;
        end else if (cmp_gt_i) begin
            loExt = {2'b00, guess_q} + ONE_EXT;
        end
        flagsOneHot = (cmp_lt_i ^ cmp_gt_i ^ cmp_eq_i) & ~(cmp_lt_i & cmp_gt_i & cmp_eq_i);
        rangeEmpty  = $signed(loExt) > $signed(hiExt);
        lo_d        = RW'(loExt);
        hi_d        = RW'(hiExt);
        guess_d     = WIDTH'((loExt + hiExt) >> 1);
    end

    // Search sequencer: IDLE waits for start, PROBE issues one guess per
    // clock, DONE raises the one-cycle completion pulse. All outputs are
    // registered here so the comparator sees a glitch-free b operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        lo_q    <= '0;
                        hi_q    <= RW'(TOP_INT);
                        guess_q <= WIDTH'(TOP_INT >> 1);
                        found_q <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= PROBE;
                    end
                end
                PROBE: begin
                    if (!flagsOneHot) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (cmp_eq_i) begin
                        result_q <= guess_q;
                        found_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        lo_q <= lo_d;
                        hi_q <= hi_d;
                        if (rangeEmpty) begin
                            found_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            guess_q <= guess_d;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign guess_o  = guess_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign found_o  = found_q;
    assign err_o    = err_q;
    assign result_o = result_q;

endmodule
